// File: rtl/panda_icb_arb_mux.sv
// -----------------------------------------------------------------------------
// panda_icb_arb_mux
//   N-master to 1-slave ICB interconnect. Command channels are arbitrated
//   (round-robin or fixed priority) and passed through with zero latency.
//   Granted master indices are queued in an in-order FIFO so that slave
//   responses are routed back in issue order.
//
// Parameters
//   M_NUM       number of masters (2..16)
//   ADDR_WIDTH  ICB address width
//   DATA_WIDTH  ICB data width (multiple of 8)
//   OUTSTANDING grant-ID FIFO depth (power of 2, 1..16)
//   FIXED_PRIO  0 = round-robin, 1 = fixed priority (lowest index wins)
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   m_cmd_addr/read/wdata/wmask     per-master command fields (packed, master i at slice i)
//   m_cmd_valid / m_cmd_ready       per-master command handshake
//   m_rsp_rdata/err                 per-master response fields (broadcast)
//   m_rsp_valid / m_rsp_ready       per-master response handshake
//   s_cmd_*                         slave command channel
//   s_rsp_*                         slave response channel
//   stats_clr, gnt_cnt              only when PANDA_ICB_ARB_MUX_STATS_EN is defined:
//                                   sync clear and per-master 16-bit saturating
//                                   handshake counters
// -----------------------------------------------------------------------------
module panda_icb_arb_mux #(
  parameter int M_NUM       = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int OUTSTANDING = 4,
  parameter int FIXED_PRIO  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef PANDA_ICB_ARB_MUX_STATS_EN
  input  logic                        stats_clr,
  output logic [M_NUM*16-1:0]         gnt_cnt,
`endif
  input  logic [M_NUM*ADDR_WIDTH-1:0] m_cmd_addr,
  input  logic [M_NUM-1:0]            m_cmd_read,
  input  logic [M_NUM*DATA_WIDTH-1:0] m_cmd_wdata,
  input  logic [M_NUM*DATA_WIDTH/8-1:0] m_cmd_wmask,
  input  logic [M_NUM-1:0]            m_cmd_valid,
  output logic [M_NUM-1:0]            m_cmd_ready,
  output logic [M_NUM*DATA_WIDTH-1:0] m_rsp_rdata,
  output logic [M_NUM-1:0]            m_rsp_err,
  output logic [M_NUM-1:0]            m_rsp_valid,
  input  logic [M_NUM-1:0]            m_rsp_ready,
  output logic [ADDR_WIDTH-1:0]       s_cmd_addr,
  output logic                        s_cmd_read,
  output logic [DATA_WIDTH-1:0]       s_cmd_wdata,
  output logic [DATA_WIDTH/8-1:0]     s_cmd_wmask,
  output logic                        s_cmd_valid,
  input  logic                        s_cmd_ready,
  input  logic [DATA_WIDTH-1:0]       s_rsp_rdata,
  input  logic                        s_rsp_err,
  input  logic                        s_rsp_valid,
  output logic                        s_rsp_ready
);

  localparam int GW = (M_NUM > 1) ? $clog2(M_NUM) : 1;
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t        state_r, state_nxt_s;
  logic [GW-1:0] gnt_r, gnt_s, arb_gnt_s, rr_ptr_r, head_s;
  logic [GW-1:0] fifo_mem_r [OUTSTANDING];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          fifo_full_s, fifo_empty_s, push_s, pop_s;

  assign fifo_full_s  = (count_r == CW'(OUTSTANDING));
  assign fifo_empty_s = (count_r == CW'(0));
  assign push_s       = s_cmd_valid & s_cmd_ready;
  assign pop_s        = s_rsp_valid & s_rsp_ready;
  assign head_s       = fifo_mem_r[rd_ptr_r];
  // While locked the registered grant is used so slave fields stay stable.
  assign gnt_s        = (state_r == ST_LOCK) ? gnt_r : arb_gnt_s;

  // Arbiter: first valid index from rr_ptr upward (wrapping), or lowest index.
  always_comb begin
    logic          found_v;
    logic          hit_v;
    logic [GW:0]   sum_v;
    logic [GW-1:0] idx_v;
    arb_gnt_s = (FIXED_PRIO != 0) ? GW'(0) : rr_ptr_r;
    found_v   = 1'b0;
    hit_v     = 1'b0;
    sum_v     = '0;
    idx_v     = '0;
    for (int k = 0; k < M_NUM; k++) begin
      sum_v     = {1'b0, rr_ptr_r} + (GW+1)'(k);
      sum_v     = (sum_v >= (GW+1)'(M_NUM)) ? (sum_v - (GW+1)'(M_NUM)) : sum_v;
      idx_v     = (FIXED_PRIO != 0) ? GW'(k) : sum_v[GW-1:0];
      hit_v     = ~found_v & m_cmd_valid[idx_v];
      arb_gnt_s = hit_v ? idx_v : arb_gnt_s;
      found_v   = found_v | hit_v;
    end
  end

  // Grant FSM state register (plus held grant).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_ARB;
      gnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      gnt_r   <= gnt_s;
    end
  end

  // Grant FSM next state: lock on a stalled command, unlock on handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ARB:  state_nxt_s = (s_cmd_valid & ~s_cmd_ready) ? ST_LOCK : ST_ARB;
      ST_LOCK: state_nxt_s = push_s ? ST_ARB : ST_LOCK;
      default: state_nxt_s = ST_ARB;
    endcase
  end

  // Grant FSM outputs: command mux and response demux, all gated by reset.
  always_comb begin
    s_cmd_valid  = rst_n & m_cmd_valid[gnt_s] & ~fifo_full_s;
    s_cmd_addr   = rst_n ? m_cmd_addr[gnt_s*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    s_cmd_read   = rst_n & m_cmd_read[gnt_s];
    s_cmd_wdata  = rst_n ? m_cmd_wdata[gnt_s*DATA_WIDTH +: DATA_WIDTH] : '0;
    s_cmd_wmask  = rst_n ? m_cmd_wmask[gnt_s*MW +: MW] : '0;
    m_cmd_ready  = '0;
    m_cmd_ready[gnt_s] = rst_n & s_cmd_ready & ~fifo_full_s;
    m_rsp_valid  = '0;
    m_rsp_valid[head_s] = rst_n & s_rsp_valid & ~fifo_empty_s;
    s_rsp_ready  = rst_n & m_rsp_ready[head_s] & ~fifo_empty_s;
    m_rsp_rdata  = rst_n ? {M_NUM{s_rsp_rdata}} : '0;
    m_rsp_err    = rst_n ? {M_NUM{s_rsp_err}} : '0;
  end

  // Grant-ID FIFO and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      rr_ptr_r <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        fifo_mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= gnt_s;
        wr_ptr_r <= (wr_ptr_r == PW'(OUTSTANDING-1)) ? PW'(0) : wr_ptr_r + PW'(1);
        rr_ptr_r <= (gnt_s == GW'(M_NUM-1)) ? GW'(0) : gnt_s + GW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PW'(OUTSTANDING-1)) ? PW'(0) : rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef PANDA_ICB_ARB_MUX_STATS_EN
  logic [15:0] cnt_r [M_NUM];

  for (genvar g = 0; g < M_NUM; g++) begin : g_stats
    // Per-master saturating handshake counter; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r[g] <= 16'h0000;
      end else if (stats_clr) begin
        cnt_r[g] <= 16'h0000;
      end else if (push_s && (gnt_s == GW'(g)) && (cnt_r[g] != 16'hFFFF)) begin
        cnt_r[g] <= cnt_r[g] + 16'h0001;
      end else begin
        cnt_r[g] <= cnt_r[g];
      end
    end
    assign gnt_cnt[g*16 +: 16] = cnt_r[g];
  end
`endif

endmodule

// File: tb/tb_panda_icb_arb_mux.sv
module tb_panda_icb_arb_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] m_cmd_addr, m_cmd_wdata, m_rsp_rdata;
  logic [15:0]  m_cmd_wmask;
  logic [3:0]   m_cmd_read, m_cmd_valid, m_cmd_ready, m_rsp_err, m_rsp_valid, m_rsp_ready;
  logic [31:0]  s_cmd_addr, s_cmd_wdata, s_rsp_rdata;
  logic [3:0]   s_cmd_wmask;
  logic         s_cmd_read, s_cmd_valid, s_cmd_ready, s_rsp_err, s_rsp_valid, s_rsp_ready;
`ifdef PANDA_ICB_ARB_MUX_STATS_EN
  logic         stats_clr;
  logic [63:0]  gnt_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int exp_gnt [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  panda_icb_arb_mux #(
    .M_NUM(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .OUTSTANDING(4), .FIXED_PRIO(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef PANDA_ICB_ARB_MUX_STATS_EN
    .stats_clr(stats_clr), .gnt_cnt(gnt_cnt),
`endif
    .m_cmd_addr(m_cmd_addr), .m_cmd_read(m_cmd_read), .m_cmd_wdata(m_cmd_wdata),
    .m_cmd_wmask(m_cmd_wmask), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err), .m_rsp_valid(m_rsp_valid),
    .m_rsp_ready(m_rsp_ready),
    .s_cmd_addr(s_cmd_addr), .s_cmd_read(s_cmd_read), .s_cmd_wdata(s_cmd_wdata),
    .s_cmd_wmask(s_cmd_wmask), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_rsp_rdata(s_rsp_rdata), .s_rsp_err(s_rsp_err), .s_rsp_valid(s_rsp_valid),
    .s_rsp_ready(s_rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // master i: addr A000000i, wdata D000000i, read = odd index, m0 mask 4'h3
    m_cmd_addr  = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
    m_cmd_wdata = {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};
    m_cmd_wmask = 16'hFFF3;
    m_cmd_read  = 4'b1010;
    s_rsp_rdata = 32'h0;
    s_rsp_err   = 1'b0;
`ifdef PANDA_ICB_ARB_MUX_STATS_EN
    stats_clr   = 1'b0;
`endif
    // reset state with every input active
    rst_n       = 1'b0;
    m_cmd_valid = 4'hF;
    s_cmd_ready = 1'b1;
    s_rsp_valid = 1'b1;
    m_rsp_ready = 4'hF;
    #12;
    chk("rst_s_cmd_valid", s_cmd_valid, 1'b0);
    chk("rst_m_cmd_ready", m_cmd_ready, 4'h0);
    chk("rst_s_rsp_ready", s_rsp_ready, 1'b0);
    chk("rst_m_rsp_valid", m_rsp_valid, 4'h0);
    chk("rst_s_cmd_addr", s_cmd_addr, 32'h0);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    m_cmd_valid = 4'h0;
    s_rsp_valid = 1'b0;

    // round-robin fairness: all valid, responses drain each cycle
    m_cmd_valid = 4'hF;
    s_rsp_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready", m_cmd_ready, 4'b0001 << exp_gnt[k]);
      chk("rr_addr", s_cmd_addr, 32'hA0000000 + exp_gnt[k]);
      tick();
    end
    m_cmd_valid = 4'h0;
    #1;
    chk("rr_tail_rsp", m_rsp_valid, 4'b1000);
    tick();
    s_rsp_valid = 1'b0;

    // lock: m0/m1 valid, slave stalls 3 cycles
    m_cmd_valid = 4'b0011;
    s_cmd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lock_addr", s_cmd_addr, 32'hA0000000);
      chk("lock_ready", m_cmd_ready, 4'h0);
      chk("lock_valid", s_cmd_valid, 1'b1);
      tick();
    end
    s_cmd_ready = 1'b1;
    #1;
    chk("lock_release", m_cmd_ready, 4'b0001);
    tick();
    #1;
    chk("lock_next_m1", m_cmd_ready, 4'b0010);
    chk("lock_next_addr", s_cmd_addr, 32'hA0000001);
    tick();
    m_cmd_valid = 4'h0;
    // drain m0 then m1, with broadcast data/err
    s_rsp_valid = 1'b1;
    s_rsp_rdata = 32'h12345678;
    s_rsp_err   = 1'b1;
    #1;
    chk("lock_rsp0", m_rsp_valid, 4'b0001);
    chk("bcast_rdata", m_rsp_rdata[96 +: 32], 32'h12345678);
    chk("bcast_err", m_rsp_err, 4'hF);
    tick();
    #1;
    chk("lock_rsp1", m_rsp_valid, 4'b0010);
    tick();
    #1;
    chk("stray_m_rsp_valid", m_rsp_valid, 4'h0);
    chk("stray_s_rsp_ready", s_rsp_ready, 1'b0);
    s_rsp_valid = 1'b0;
    s_rsp_err   = 1'b0;

    // FIFO full: m2 issues 5 commands, no responses
    m_cmd_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("full_hs", m_cmd_ready, 4'b0100);
      tick();
    end
    #1;
    chk("full_s_valid", s_cmd_valid, 1'b0);
    chk("full_ready", m_cmd_ready, 4'h0);
    s_rsp_valid = 1'b1;
    #1;
    chk("full_pop_srdy", s_rsp_ready, 1'b1);
    chk("full_pop_mvalid", m_rsp_valid, 4'b0100);
    chk("full_no_push_same", s_cmd_valid, 1'b0);
    tick();
    s_rsp_valid = 1'b0;
    #1;
    chk("full_push_next", s_cmd_valid, 1'b1);
    chk("full_push_ready", m_cmd_ready, 4'b0100);
    tick();
    m_cmd_valid = 4'h0;
    s_rsp_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("full_drain", m_rsp_valid, 4'b0100);
      tick();
    end
    s_rsp_valid = 1'b0;

    // ordered routing: m2, m0, m2
    m_cmd_valid = 4'b0100;
    #1;
    chk("ord_cmd0", m_cmd_ready, 4'b0100);
    tick();
    m_cmd_valid = 4'b0001;
    #1;
    chk("ord_cmd1", m_cmd_ready, 4'b0001);
    chk("ord_wdata", s_cmd_wdata, 32'hD0000000);
    chk("ord_wmask", s_cmd_wmask, 4'h3);
    chk("ord_read", s_cmd_read, 1'b0);
    tick();
    m_cmd_valid = 4'b0100;
    #1;
    chk("ord_cmd2", m_cmd_ready, 4'b0100);
    tick();
    m_cmd_valid = 4'h0;
    s_rsp_valid = 1'b1;
    s_rsp_rdata = 32'hCAFE0001;
    #1;
    chk("ord_rsp0", m_rsp_valid, 4'b0100);
    chk("ord_rdata", m_rsp_rdata[64 +: 32], 32'hCAFE0001);
    tick();
    m_rsp_ready = 4'b1110;
    #1;
    chk("ord_rsp1", m_rsp_valid, 4'b0001);
    chk("ord_bp", s_rsp_ready, 1'b0);
    tick();
    #1;
    chk("ord_rsp1_hold", m_rsp_valid, 4'b0001);
    m_rsp_ready = 4'hF;
    #1;
    chk("ord_bp_release", s_rsp_ready, 1'b1);
    tick();
    #1;
    chk("ord_rsp2", m_rsp_valid, 4'b0100);
    tick();
    s_rsp_valid = 1'b0;

    // reset mid-flight: m1, m2 outstanding, rr_ptr left at 3
    m_cmd_valid = 4'b0010;
    #1;
    chk("mid_cmd0", m_cmd_ready, 4'b0010);
    tick();
    m_cmd_valid = 4'b0100;
    #1;
    chk("mid_cmd1", m_cmd_ready, 4'b0100);
    tick();
    m_cmd_valid = 4'h0;
    #1;
    chk("pre_rst_srdy", s_rsp_ready, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    s_rsp_valid = 1'b1;
    #1;
    chk("post_rst_srdy", s_rsp_ready, 1'b0);
    chk("post_rst_mvalid", m_rsp_valid, 4'h0);
    s_rsp_valid = 1'b0;
    m_cmd_valid = 4'hF;
    #1;
    chk("post_rst_gnt", m_cmd_ready, 4'b0001);
    m_cmd_valid = 4'h0;

`ifdef PANDA_ICB_ARB_MUX_STATS_EN
    // stats: m1 handshakes every cycle, saturate, then clear
    m_cmd_valid = 4'b0010;
    s_rsp_valid = 1'b1;
    repeat (5) tick();
    chk("stats_cnt5", gnt_cnt[16 +: 16], 16'd5);
    repeat (70000) tick();
    chk("stats_sat", gnt_cnt[16 +: 16], 16'hFFFF);
    chk("stats_m0", gnt_cnt[0 +: 16], 16'h0000);
    stats_clr = 1'b1;
    tick();
    chk("stats_clr", gnt_cnt[16 +: 16], 16'h0000);
    stats_clr = 1'b0;
    m_cmd_valid = 4'h0;
    s_rsp_valid = 1'b0;
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
